// File: rtl/prod_accum_pkg.sv
// Shared types and helpers for the saturating product accumulator.
// The helpers take widths as arguments so each instance can size its own limits.
package prod_accum_pkg;

    typedef enum logic [0:0] {ST_ACC, ST_HOLD} state_e;

    // Largest positive value of a w-bit two's-complement number, right-aligned in 32 bits.
    function automatic logic [31:0] acc_max(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Most negative w-bit value, sign-extended to 32 bits; truncation to w bits yields 10..0.
    function automatic logic [31:0] acc_min(input int unsigned w);
        return 32'hffff_ffff << (w - 1);
    endfunction

    // Sign-extend the low w bits of v to 33 bits.
    function automatic logic [32:0] sext(input logic [31:0] v, input int unsigned w);
        logic [32:0] r;
        r = {1'b0, v};
        for (int unsigned i = 0; i < 33; i++) begin
            if (i >= w) r[i] = v[5'(w - 1)];
        end
        return r;
    endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Product-in / frame-result-out handshake bundle of the accumulator.
// master = upstream multiplier plus result consumer; slave = accumulator.
interface prod_accum_if #(
    parameter int unsigned P_W   = 16,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [P_W-1:0]   in_p;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_p, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_p, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_ovf
    );
endinterface

// File: rtl/prod_accum_sat_add.sv
// Combinational saturating add of a sign-extended product onto the accumulator.
// The sum is formed one bit wider than the accumulator so overflow is never lost.
module prod_accum_sat_add
    import prod_accum_pkg::*;
#(
    parameter int unsigned P_W   = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [P_W-1:0]   p,
    output logic [ACC_W-1:0] sum,
    output logic             clamp
);
    localparam logic [ACC_W-1:0] AccMax = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] AccMin = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] p_ext;
    logic [ACC_W:0] full;

    assign p_ext = (ACC_W + 1)'(sext(32'(p), P_W));
    assign full  = {acc[ACC_W-1], acc} + p_ext;

    // Top two bits disagree exactly when the result leaves the ACC_W-bit range.
    always_comb begin
        clamp = full[ACC_W] ^ full[ACC_W-1];
        sum   = full[ACC_W-1:0];
        if (clamp) begin
            sum = full[ACC_W] ? AccMin : AccMax;
        end
    end
endmodule

// File: rtl/prod_accum.sv
// Frame accumulator: sums signed products with saturation and a sticky clamp flag,
// then holds the frame result until the consumer takes it.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned P_W   = 16,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    prod_accum_if.slave  bus
);
    state_e state_q, state_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             out_ovf_q;

    logic [ACC_W-1:0] sum_nxt;
    logic             clamp;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             in_ready;
    logic             out_valid;
    logic             take;

    prod_accum_sat_add #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc   (acc_q),
        .p     (bus.in_p),
        .sum   (sum_nxt),
        .clamp (clamp)
    );

    assign take    = bus.in_valid & in_ready;
    assign cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_nxt = ovf_q | clamp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACC:  if (take && bus.in_last) state_d = ST_HOLD;
            ST_HOLD: if (bus.out_ready)       state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // Handshake outputs decode only the state register, never the live inputs.
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else if (take) begin
            if (bus.in_last) begin
                out_sum_q <= sum_nxt;
                out_cnt_q <= cnt_nxt;
                out_ovf_q <= ovf_nxt;
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
            end else begin
                acc_q     <= sum_nxt;
                cnt_q     <= cnt_nxt;
                ovf_q     <= ovf_nxt;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum (ACC_W=17 so saturation is reachable with 16-bit products).
// Stimulus pushes expected frame results; a monitor pops and compares on out_valid.
module tb_prod_accum;
    localparam int unsigned P_W   = 16;
    localparam int unsigned ACC_W = 17;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        int sum;
        int cnt;
        bit ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t sb[$];
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   last_acc_cyc = 0;
    int   ready_mode   = 0;   // 0: always ready, 1: never ready, 2: random

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prod_accum_if #(.P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    prod_accum #(
        .P_W   (P_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int dut_sum();
        return int'($signed(bus.out_sum));
    endfunction

    function automatic exp_t model(input int ps[$]);
        exp_t   e;
        longint a  = 0;
        longint hi = (longint'(1) << (ACC_W - 1)) - 1;
        longint lo = -(longint'(1) << (ACC_W - 1));
        e.ovf = 1'b0;
        foreach (ps[i]) begin
            a = a + ps[i];
            if (a > hi) begin
                a = hi;
                e.ovf = 1'b1;
            end else if (a < lo) begin
                a = lo;
                e.ovf = 1'b1;
            end
        end
        e.sum = int'(a);
        e.cnt = (ps.size() > 255) ? 255 : ps.size();
        return e;
    endfunction

    task automatic push(input int sum, input int cnt, input bit ovf);
        exp_t e;
        e.sum = sum;
        e.cnt = cnt;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic beat(input int p, input bit last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_p     = 16'(p);
        bus.in_last  = last;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready stayed 0, required 1");
        end
        if (last) last_acc_cyc = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_p     = '0;
    endtask

    task automatic send_frame(input int ps[$], input int max_gap);
        foreach (ps[i]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            beat(ps[i], i == ps.size() - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: pops on the first cycle of each result, then checks stability while held.
    initial begin : monitor
        exp_t cur;
        bit   seen;
        seen          = 1'b0;
        cur.sum       = 0;
        cur.cnt       = 0;
        cur.ovf       = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                continue;
            end
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("result_latency", cyc, last_acc_cyc);
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_result: sum %0d with empty scoreboard", dut_sum());
                    end else begin
                        cur = sb.pop_front();
                    end
                end
                check("out_sum", dut_sum(), cur.sum);
                check("out_cnt", bus.out_cnt, cur.cnt);
                check("out_ovf", bus.out_ovf, cur.ovf);
                check("in_ready_hold", bus.in_ready, 0);
            end else begin
                check("in_ready_idle", bus.in_ready, 1);
            end
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.out_valid && bus.out_ready) seen = 1'b0;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int   q[$];
        exp_t e;
        bus.in_valid = 1'b0;
        bus.in_p     = '0;
        bus.in_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_sum", dut_sum(), 0);
        check("rst_out_cnt", bus.out_cnt, 0);
        check("rst_out_ovf", bus.out_ovf, 0);

        // Reset mid-frame discards the partial sum
        beat(10, 1'b0);
        beat(20, 1'b0);
        beat(30, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        push(5, 1, 1'b0);
        beat(5, 1'b1);
        drain();

        // Mixed-sign frame
        push(57, 3, 1'b0);
        q = '{100, -50, 7};
        send_frame(q, 0);
        drain();

        // Positive saturation, then a clean frame
        push(65535, 3, 1'b1);
        q = '{32767, 32767, 32767};
        send_frame(q, 0);
        push(1, 1, 1'b0);
        q = '{1};
        send_frame(q, 0);
        drain();

        // Negative saturation; later adds start from the clamped value
        push(-65536, 3, 1'b1);
        q = '{-32768, -32768, -32768};
        send_frame(q, 0);
        push(-64536, 4, 1'b1);
        q = '{-32768, -32768, -32768, 1000};
        send_frame(q, 0);
        drain();

        // Backpressure: result held, new beat refused until the handshake
        ready_mode = 1;
        push(7, 2, 1'b0);
        q = '{3, 4};
        send_frame(q, 0);
        push(9, 1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_p     = 16'd9;
        bus.in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        ready_mode = 0;
        @(negedge clk);
        check("bp_in_ready_pre_hs", bus.in_ready, 0);
        @(negedge clk);
        check("bp_in_ready_post_hs", bus.in_ready, 1);
        last_acc_cyc = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        drain();

        // Long frame: beat count saturates at 255
        q = {};
        for (int i = 0; i < 300; i++) q.push_back(1);
        push(300, 255, 1'b0);
        send_frame(q, 0);
        drain();

        // Random gaps and random consumer readiness against the reference model
        ready_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            int len;
            len = int'($urandom_range(1, 6));
            q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 1) q.push_back(int'($urandom_range(0, 65535)) - 32768);
                else q.push_back(int'($urandom_range(0, 400)) - 200);
            end
            e = model(q);
            sb.push_back(e);
            send_frame(q, 2);
        end
        ready_mode = 0;
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
